// File: rtl/hs_arb_pkg.sv
// Shared types and default sizing for the hiscore RAM port arbiter.
package hs_arb_pkg;

    localparam int HS_AW         = 6;
    localparam int HS_DW         = 8;
    localparam int HS_FIFO_DEPTH = 4;
    localparam int HS_PAUSEPAD   = 2;
    localparam int HS_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_RELEASE = 3'd4
    } hs_arb_state_t;

    typedef struct packed {
        logic [HS_AW-1:0] addr;
        logic [HS_DW-1:0] data;
    } hs_wr_entry_t;

    // The CPU must stay paused in every state that may touch the RAM port.
    function automatic logic holds_pause(input hs_arb_state_t st);
        return (st == ST_REQ) || (st == ST_SETTLE) || (st == ST_ACCESS);
    endfunction

endpackage

// File: rtl/hs_wr_fifo.sv
// Small synchronous FIFO buffering download writes; push and pop may coincide, even when full.
module hs_wr_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   cnt_r;
    logic          do_push_s;
    logic          do_pop_s;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    assign full  = (cnt_r == FULL_CNT);
    assign empty = (cnt_r == {(PW+1){1'b0}});
    assign dout  = mem_r[rd_ptr_r];

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            else           wr_ptr_r <= wr_ptr_r;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            else           rd_ptr_r <= rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/hs_port_arbiter.sv
// Hiscore RAM port owner: pauses the CPU around NVRAM download/upload and serialises port use.
// Optional running XOR of written bytes on port csum when HS_PORT_ARB_CHECKSUM_EN is defined.
module hs_port_arbiter
    import hs_arb_pkg::*;
#(
    parameter int AW         = HS_AW,
    parameter int DW         = HS_DW,
    parameter int FIFO_DEPTH = HS_FIFO_DEPTH,
    parameter int PAUSEPAD   = HS_PAUSEPAD,
    parameter int TIMEOUT    = HS_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    input  logic          ul_active,
    input  logic          ul_rd,
    input  logic [AW-1:0] ul_addr,
    output logic [DW-1:0] ul_data,
    output logic          ul_valid,
    input  logic          paused,
    output logic          pause_req,
    output logic [AW-1:0] hs_addr,
    output logic [DW-1:0] hs_wdata,
    output logic          hs_we,
    input  logic [DW-1:0] hs_rdata,
    output logic          busy,
    output logic          ovf,
    output logic          tmo
`ifdef HS_PORT_ARB_CHECKSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);
    localparam int             TCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int             PCW       = (PAUSEPAD > 1) ? $clog2(PAUSEPAD) : 1;
    localparam logic [TCW-1:0] WAIT_LAST = TCW'(TIMEOUT - 1);
    localparam logic [PCW-1:0] PAD_LAST  = PCW'(PAUSEPAD - 1);

    hs_arb_state_t state_r, state_n;
    logic [TCW-1:0] wait_cnt_r;
    logic [PCW-1:0] pad_cnt_r;
    logic           rd_pend_r, rd_fl1_r, rd_fl2_r;
    logic [AW-1:0]  rd_pend_addr_r;
    logic [DW-1:0]  ul_data_r, hs_wdata_r;
    logic [AW-1:0]  hs_addr_r;
    logic           ul_valid_r, pause_req_r, hs_we_r, busy_r, ovf_r, tmo_r;

    logic [AW+DW-1:0] fifo_head_s;
    logic             fifo_full_s, fifo_empty_s;
    logic             in_access_s, drain_s, bypass_s, issue_wr_s, issue_rd_s;
    logic             push_s, drop_s, wait_done_s, timeout_s, pad_run_s;
    logic             session_start_s, traffic_done_s;
    logic [AW-1:0]    wr_addr_s, rd_addr_s;
    logic [DW-1:0]    wr_data_s;

    hs_wr_fifo #(.W(AW + DW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (drain_s),
        .din   ({dl_addr, dl_data}),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Port-op selection: queued writes first, then a write arriving into an empty queue, then reads.
    always_comb begin
        in_access_s     = (state_r == ST_ACCESS);
        drain_s         = in_access_s & ~fifo_empty_s;
        bypass_s        = in_access_s & fifo_empty_s & dl_wr;
        issue_wr_s      = drain_s | bypass_s;
        issue_rd_s      = in_access_s & ~issue_wr_s & (ul_rd | rd_pend_r);
        rd_addr_s       = ul_rd ? ul_addr : rd_pend_addr_r;
        wr_addr_s       = drain_s ? fifo_head_s[AW+DW-1:DW] : dl_addr;
        wr_data_s       = drain_s ? fifo_head_s[DW-1:0] : dl_data;
        push_s          = dl_wr & (state_r != ST_IDLE) & ~bypass_s;
        drop_s          = dl_wr & ((state_r == ST_IDLE) | (push_s & fifo_full_s & ~drain_s));
        wait_done_s     = (wait_cnt_r == WAIT_LAST);
        timeout_s       = (state_r == ST_REQ) & ~paused & wait_done_s;
        pad_run_s       = (state_r == ST_SETTLE) & (paused | tmo_r);
        session_start_s = (state_r == ST_IDLE) & (dl_active | ul_active);
        traffic_done_s  = ~dl_active & ~ul_active & ~dl_wr & ~ul_rd & fifo_empty_s
                          & ~rd_pend_r & ~rd_fl1_r & ~rd_fl2_r;
    end

    // Next-state logic; after a timeout the settle count no longer waits for paused.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dl_active | ul_active) state_n = ST_REQ;
                else                       state_n = ST_IDLE;
            end
            ST_REQ: begin
                if (paused | wait_done_s) state_n = ST_SETTLE;
                else                      state_n = ST_REQ;
            end
            ST_SETTLE: begin
                if (pad_run_s && (pad_cnt_r == PAD_LAST)) state_n = ST_ACCESS;
                else                                     state_n = ST_SETTLE;
            end
            ST_ACCESS: begin
                if (traffic_done_s) state_n = ST_RELEASE;
                else                state_n = ST_ACCESS;
            end
            ST_RELEASE: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // State register with pause-wait and settle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {TCW{1'b0}};
            pad_cnt_r  <= {PCW{1'b0}};
        end else begin
            state_r <= state_n;
            if ((state_r == ST_REQ) && (state_n == ST_REQ)) wait_cnt_r <= wait_cnt_r + TCW'(1);
            else                                            wait_cnt_r <= {TCW{1'b0}};
            if (pad_run_s && (state_n == ST_SETTLE)) pad_cnt_r <= pad_cnt_r + PCW'(1);
            else                                     pad_cnt_r <= {PCW{1'b0}};
        end
    end

    // Status outputs; sticky flags clear at the start of each session, a new drop wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_req_r <= 1'b0;
            busy_r      <= 1'b0;
            ovf_r       <= 1'b0;
            tmo_r       <= 1'b0;
        end else begin
            pause_req_r <= holds_pause(state_n);
            busy_r      <= (state_n != ST_IDLE);
            if (drop_s)               ovf_r <= 1'b1;
            else if (session_start_s) ovf_r <= 1'b0;
            else                      ovf_r <= ovf_r;
            if (timeout_s)            tmo_r <= 1'b1;
            else if (session_start_s) tmo_r <= 1'b0;
            else                      tmo_r <= tmo_r;
        end
    end

    // RAM port registers; address and data hold between ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_we_r    <= 1'b0;
            hs_addr_r  <= {AW{1'b0}};
            hs_wdata_r <= {DW{1'b0}};
        end else begin
            hs_we_r <= issue_wr_s;
            if (issue_wr_s) begin
                hs_addr_r  <= wr_addr_s;
                hs_wdata_r <= wr_data_s;
            end else if (issue_rd_s) begin
                hs_addr_r  <= rd_addr_s;
                hs_wdata_r <= hs_wdata_r;
            end else begin
                hs_addr_r  <= hs_addr_r;
                hs_wdata_r <= hs_wdata_r;
            end
        end
    end

    // Read path: pending slot, two in-flight stages matching the registered RAM, then capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_r      <= 1'b0;
            rd_pend_addr_r <= {AW{1'b0}};
            rd_fl1_r       <= 1'b0;
            rd_fl2_r       <= 1'b0;
            ul_valid_r     <= 1'b0;
            ul_data_r      <= {DW{1'b0}};
        end else begin
            if (issue_rd_s) begin
                rd_pend_r      <= 1'b0;
                rd_pend_addr_r <= rd_pend_addr_r;
            end else if (ul_rd) begin
                rd_pend_r      <= 1'b1;
                rd_pend_addr_r <= ul_addr;
            end else begin
                rd_pend_r      <= rd_pend_r;
                rd_pend_addr_r <= rd_pend_addr_r;
            end
            rd_fl1_r   <= issue_rd_s;
            rd_fl2_r   <= rd_fl1_r;
            ul_valid_r <= rd_fl2_r;
            if (rd_fl2_r) ul_data_r <= hs_rdata;
            else          ul_data_r <= ul_data_r;
        end
    end

`ifdef HS_PORT_ARB_CHECKSUM_EN
    logic [DW-1:0] csum_r;

    // XOR of every byte issued to the port in the current session.
    always_ff @(posedge clk) begin
        if (reset)                csum_r <= {DW{1'b0}};
        else if (session_start_s) csum_r <= {DW{1'b0}};
        else if (issue_wr_s)      csum_r <= csum_r ^ wr_data_s;
        else                      csum_r <= csum_r;
    end

    assign csum = csum_r;
`endif

    assign ul_data   = ul_data_r;
    assign ul_valid  = ul_valid_r;
    assign pause_req = pause_req_r;
    assign hs_addr   = hs_addr_r;
    assign hs_wdata  = hs_wdata_r;
    assign hs_we     = hs_we_r;
    assign busy      = busy_r;
    assign ovf       = ovf_r;
    assign tmo       = tmo_r;

endmodule

// File: tb/tb_hs_port_arbiter.sv
// Directed bench for hs_port_arbiter: vector tables for download/upload plus timing sequences.
module tb_hs_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dl_active = 1'b0, dl_wr = 1'b0, ul_active = 1'b0, ul_rd = 1'b0, paused = 1'b0;
    logic [AW-1:0] dl_addr = 6'h00, ul_addr = 6'h00;
    logic [DW-1:0] dl_data = 8'h00;
    logic [DW-1:0] ul_data, hs_wdata, hs_rdata;
    logic [AW-1:0] hs_addr;
    logic          ul_valid, pause_req, hs_we, busy, ovf, tmo;
`ifdef HS_PORT_ARB_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_ovf;
    } dl_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp_data;
    } ul_vec_t;

    dl_vec_t dl_tab [5];
    ul_vec_t ul_tab [2];

    always #5 clk = ~clk;

    hs_port_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .ul_active (ul_active),
        .ul_rd     (ul_rd),
        .ul_addr   (ul_addr),
        .ul_data   (ul_data),
        .ul_valid  (ul_valid),
        .paused    (paused),
        .pause_req (pause_req),
        .hs_addr   (hs_addr),
        .hs_wdata  (hs_wdata),
        .hs_we     (hs_we),
        .hs_rdata  (hs_rdata),
        .busy      (busy),
        .ovf       (ovf),
        .tmo       (tmo)
`ifdef HS_PORT_ARB_CHECKSUM_EN
        ,
        .csum      (csum)
`endif
    );

    // Hiscore RAM model with one-cycle registered read.
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (hs_we) ram[hs_addr] <= hs_wdata;
        hs_rdata <= ram[hs_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_we(input int max_cyc, output logic seen);
        seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            step();
            if (hs_we) seen = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   wcnt;

        dl_tab[0] = '{6'h00, 8'hA0, 1'b0};
        dl_tab[1] = '{6'h01, 8'hA1, 1'b0};
        dl_tab[2] = '{6'h02, 8'hA2, 1'b0};
        dl_tab[3] = '{6'h03, 8'hA3, 1'b0};
        dl_tab[4] = '{6'h04, 8'hA4, 1'b1};
        ul_tab[0] = '{6'h12, 8'h5A};
        ul_tab[1] = '{6'h13, 8'hC3};

        // reset state
        step(); step();
        chk("rst_pause_req", pause_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hs_we", hs_we, 0);
        chk("rst_ul_valid", ul_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_hs_addr", hs_addr, 0);
        reset = 1'b0;

        // early writes fill the FIFO, fifth is dropped, drain after settle
        dl_active = 1'b1;
        step();
        chk("req_pause_req", pause_req, 1);
        chk("req_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            dl_wr = 1'b1; dl_addr = dl_tab[i].addr; dl_data = dl_tab[i].data;
            step();
            chk("dl_ovf", ovf, dl_tab[i].exp_ovf);
            chk("dl_no_we_before_pause", hs_we, 0);
        end
        dl_wr = 1'b0;
        paused = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("settle_no_we", hs_we, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_we", hs_we, 1);
            chk("drain_addr", hs_addr, dl_tab[i].addr);
            chk("drain_data", hs_wdata, dl_tab[i].data);
        end
        dl_active = 1'b0;
        step();
        chk("dropped_byte_absent", hs_we, 0);
        chk("release_pause_req", pause_req, 0);
        chk("release_busy", busy, 1);
        step();
        chk("idle_busy", busy, 0);
        paused = 1'b0;
        step();

        // combined session: bypass writes, reads, write/read collision
        dl_active = 1'b1; ul_active = 1'b1; paused = 1'b1;
        step();
        chk("ovf_cleared_on_start", ovf, 0);
        step(); step(); step();
        for (int i = 0; i < 2; i++) begin
            dl_wr = 1'b1; dl_addr = ul_tab[i].addr; dl_data = ul_tab[i].exp_data;
            step();
            chk("bypass_we", hs_we, 1);
            chk("bypass_addr", hs_addr, ul_tab[i].addr);
            chk("bypass_data", hs_wdata, ul_tab[i].exp_data);
        end
        dl_wr = 1'b0;

        ul_rd = 1'b1; ul_addr = ul_tab[0].addr;
        step();
        ul_rd = 1'b0;
        chk("rd_issue_addr", hs_addr, ul_tab[0].addr);
        chk("rd_issue_no_we", hs_we, 0);
        step();
        chk("rd_valid_early", ul_valid, 0);
        step();
        chk("rd_valid", ul_valid, 1);
        chk("rd_data", ul_data, ul_tab[0].exp_data);
        step();
        chk("rd_valid_pulse", ul_valid, 0);

        for (int i = 0; i < 2; i++) begin
            ul_rd = 1'b1; ul_addr = ul_tab[i].addr;
            step();
        end
        ul_rd = 1'b0;
        chk("b2b_valid_early", ul_valid, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("b2b_valid", ul_valid, 1);
            chk("b2b_data", ul_data, ul_tab[i].exp_data);
        end
        step();
        chk("b2b_valid_end", ul_valid, 0);

        dl_wr = 1'b1; dl_addr = 6'h20; dl_data = 8'h77;
        ul_rd = 1'b1; ul_addr = ul_tab[1].addr;
        step();
        dl_wr = 1'b0; ul_rd = 1'b0;
        chk("coll_we_first", hs_we, 1);
        chk("coll_we_addr", hs_addr, 6'h20);
        step();
        chk("coll_rd_no_we", hs_we, 0);
        chk("coll_rd_addr", hs_addr, ul_tab[1].addr);
        step();
        chk("coll_valid_early", ul_valid, 0);
        step();
        chk("coll_valid", ul_valid, 1);
        chk("coll_data", ul_data, ul_tab[1].exp_data);

        dl_active = 1'b0; ul_active = 1'b0;
        step();
        chk("c_release_pause_req", pause_req, 0);
        step();
        chk("c_idle_busy", busy, 0);

        // write strobe while idle is dropped
        paused = 1'b0;
        dl_wr = 1'b1; dl_addr = 6'h01; dl_data = 8'hEE;
        step();
        dl_wr = 1'b0;
        chk("idle_wr_ovf", ovf, 1);
        chk("idle_wr_no_we", hs_we, 0);
        chk("idle_wr_busy", busy, 0);

        // pause never acknowledged: timeout after 16 REQ cycles, write still lands
        dl_active = 1'b1;
        step();
        chk("tmo_ovf_cleared", ovf, 0);
        chk("tmo_pause_req", pause_req, 1);
        dl_wr = 1'b1; dl_addr = 6'h05; dl_data = 8'h3C;
        step();
        dl_wr = 1'b0;
        repeat (14) step();
        chk("tmo_not_yet", tmo, 0);
        step();
        chk("tmo_set", tmo, 1);
        wait_we(8, seen);
        chk("tmo_write_seen", seen, 1);
        chk("tmo_write_addr", hs_addr, 6'h05);
        chk("tmo_write_data", hs_wdata, 8'h3C);
        dl_active = 1'b0;
        step(); step();
        chk("tmo_idle_busy", busy, 0);
        chk("tmo_sticky", tmo, 1);

        // reset in the middle of a drain with two entries still queued
        dl_active = 1'b1;
        step();
        chk("rstmid_tmo_cleared", tmo, 0);
        for (int i = 0; i < 3; i++) begin
            dl_wr = 1'b1; dl_addr = 6'(6'h30 + i); dl_data = 8'(8'h90 + i);
            step();
        end
        dl_wr = 1'b0;
        paused = 1'b1;
        wait_we(8, seen);
        chk("rstmid_first_we", seen, 1);
        chk("rstmid_first_addr", hs_addr, 6'h30);
        reset = 1'b1; dl_active = 1'b0; paused = 1'b0;
        step();
        chk("rstmid_we", hs_we, 0);
        chk("rstmid_pause_req", pause_req, 0);
        chk("rstmid_busy", busy, 0);
        reset = 1'b0;
        wcnt = 0;
        repeat (8) begin
            step();
            if (hs_we) wcnt++;
        end
        chk("rstmid_no_more_writes", wcnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_port_arbiter.md
Name: hs_port_arbiter

Overview:
- Owns the single hiscore RAM port inside the game core (6-bit address, 8-bit data).
- Sequences CPU pause around NVRAM download (host writes) and upload (host reads).
- Buffers early download writes in a small FIFO until the CPU is paused, then drains them.
- Serves upload read strobes and releases pause when all host traffic ends.

Parameters:
- AW, 6, hiscore RAM address width.
- DW, 8, data width.
- FIFO_DEPTH, 4, download write buffer entries (power of 2, ≥2).
- PAUSEPAD, 2, settle cycles after `paused` before the first port access.
- TIMEOUT, 1024, max cycles to wait for `paused` before proceeding anyway.

Ports:
- clk  in  1  system clock (12 MHz domain)
- reset  in  1  synchronous, active-high
- dl_active  in  1  NVRAM download session in progress (level)
- dl_wr  in  1  download byte strobe, one cycle
- dl_addr  in  AW  download byte address
- dl_data  in  DW  download byte
- ul_active  in  1  NVRAM upload session in progress (level)
- ul_rd  in  1  upload read strobe, one cycle
- ul_addr  in  AW  upload read address
- ul_data  out  DW  upload read data
- ul_valid  out  1  one-cycle pulse; ul_data valid
- paused  in  1  CPU pause acknowledge
- pause_req  out  1  request CPU pause
- hs_addr  out  AW  RAM port address
- hs_wdata  out  DW  RAM port write data
- hs_we  out  1  RAM port write enable
- hs_rdata  in  DW  RAM read data, registered, 1-cycle latency from hs_addr
- busy  out  1  state ≠ IDLE
- ovf  out  1  sticky: FIFO overflow (write dropped)
- tmo  out  1  sticky: pause timeout occurred

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0.
- FSM states: IDLE, REQ, SETTLE, ACCESS, RELEASE.
- IDLE → REQ when dl_active|ul_active. pause_req is 1 in REQ, SETTLE and ACCESS; 0 otherwise.
- REQ → SETTLE when paused=1 (counter cleared). REQ → SETTLE also when the wait counter reaches TIMEOUT-1; this sets tmo.
- SETTLE: counts PAUSEPAD cycles, then → ACCESS. The count restarts if paused drops.
- ACCESS, one port op per cycle. Priority: FIFO drain > pending read.
  - Drain: hs_addr=head.addr, hs_wdata=head.data, hs_we=1 for exactly one cycle, pop.
  - Read: a ul_rd arriving in ACCESS or earlier is latched (1-deep pending slot; a later strobe overwrites it). Issue hs_addr=ul_addr. ul_data is captured from hs_rdata 2 cycles after ul_rd when the port is idle. ul_valid pulses in that same cycle.
- ACCESS → RELEASE when dl_active=0, ul_active=0, FIFO empty, no pending read and no read in flight.
- RELEASE: pause_req=0 for one cycle, → IDLE.
- dl_wr is accepted in every state except IDLE and pushes to the FIFO. In ACCESS with the FIFO empty, push and pop happen the same cycle (bypass allowed; 1-cycle write latency).
- FIFO full and dl_wr without a simultaneous pop: byte dropped, ovf set. Simultaneous push+pop when full: accepted.
- dl_wr in IDLE: ignored, ovf set.
- ovf and tmo clear only on reset or on IDLE→REQ.
- hs_we is never 1 outside ACCESS.
- hs_addr holds its last value when no op is issued.
- Session re-asserted during RELEASE: go to IDLE, then REQ next cycle.
- Reset mid-ACCESS: FIFO flushed, pause_req drops in the same cycle reset is sampled.

Optional Feature:
- Macro HS_PORT_ARB_CHECKSUM_EN.
- When defined:
  - Extra output csum [DW-1:0]: running XOR of every byte written to the RAM port.
  - Cleared on IDLE→REQ.
  - Updated in the cycle hs_we=1.
- When undefined: port absent, no logic.

Decomposition:
- Package hs_arb_pkg: state enum (hs_arb_state_t), FIFO entry struct {addr, data}, default-parameter localparams.
- Sub-module hs_wr_fifo: synchronous FIFO (push/pop/full/empty, simultaneous push+pop). FSM, timeout counter and read pipeline stay in hs_port_arbiter.

Test Plan:
- dl_active rises, paused rises 5 cycles later, PAUSEPAD=2 → first hs_we 3 cycles after paused. pause_req drops 1 cycle after dl_active falls with FIFO empty.
- 4 dl_wr (addr 0..3, data A0..A3) before paused → FIFO full, ovf=0. After SETTLE, 4 consecutive hs_we cycles in order. A 5th write before paused → ovf=1, byte lost.
- Upload ul_rd at addr 0x12, RAM holds 0x5A → ul_valid 2 cycles later with ul_data=0x5A. Back-to-back reads at 0x12, 0x13 → two ul_valid pulses 1 cycle apart.
- paused held 0, TIMEOUT=16 → tmo=1 after 16 cycles in REQ, SETTLE entered, writes proceed.
- dl_wr and ul_rd in the same ACCESS cycle → write issues first, ul_valid delayed by 1 cycle.
- Reset asserted mid-drain with 2 entries queued → next cycle: hs_we=0, pause_req=0, busy=0. No further writes after reset releases.
